// File: rtl/array_1r1w_ext.sv
// rtl/array_1r1w_ext.sv - parametrised 1R1W SRAM model with lane mask, bypass and post-reset zero fill
module array_1r1w_ext #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 2048,
    parameter int MASK_W     = 2,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [DATA_W-1:0] W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [DATA_W-1:0] R0_data,
    output logic              R0_valid
);

    localparam int LANE_W = DATA_W / MASK_W;
    // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] ram [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              rd_in_range;
    logic              bypass_hit;
    logic [DATA_W-1:0] rd_word;

    assign init_busy   = (INIT_CLEAR != 0) && (state == CLEAR);
    assign wr_ok       = W0_en && !init_busy && !reset && ({1'b0, W0_addr} < DEPTH_C);
    assign rd_ok       = R0_en && !init_busy && !reset;
    assign rd_in_range = {1'b0, R0_addr} < DEPTH_C;
    assign bypass_hit  = (BYPASS != 0) && wr_ok && (W0_addr == R0_addr);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST_C) begin
                state <= IDLE;
            end
        end
    end

    // Port writes cannot collide with the clear: wr_ok is masked by init_busy.
    always_ff @(posedge clock) begin
        if (init_busy && !reset) begin
            ram[clr_ptr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    ram[W0_addr][i*LANE_W +: LANE_W] <= W0_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = ram[R0_addr];
        end
        if (bypass_hit) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = W0_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            R0_valid <= 1'b0;
            R0_data  <= '0;
        end else begin
            R0_valid <= rd_ok;
            if (rd_ok) begin
                R0_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_array_1r1w_ext.sv
// tb/tb_array_1r1w_ext.sv - randomized bench for array_1r1w_ext across three geometries
module tb_array_1r1w_ext;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    waddr, raddr;
    logic          we, re;
    logic [2047:0] wdata;
    logic [1:0]    wmask2;
    logic [3:0]    wmask4;

    logic [2047:0] d0, d1, d2;
    logic          v0, v1, v2, b0, b1, b2;
    logic [2047:0] r_data [3];
    logic          r_valid [3];
    logic          busy [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // u0: default, u1: no bypass, u2: 200 words x 4 lanes
    array_1r1w_ext u0 (
        .clock(clock), .reset(reset), .init_busy(b0),
        .W0_addr(waddr), .W0_en(we), .W0_data(wdata), .W0_mask(wmask2),
        .R0_addr(raddr), .R0_en(re), .R0_data(d0), .R0_valid(v0)
    );
    array_1r1w_ext #(.BYPASS(0)) u1 (
        .clock(clock), .reset(reset), .init_busy(b1),
        .W0_addr(waddr), .W0_en(we), .W0_data(wdata), .W0_mask(wmask2),
        .R0_addr(raddr), .R0_en(re), .R0_data(d1), .R0_valid(v1)
    );
    array_1r1w_ext #(.DEPTH(200), .MASK_W(4)) u2 (
        .clock(clock), .reset(reset), .init_busy(b2),
        .W0_addr(waddr), .W0_en(we), .W0_data(wdata), .W0_mask(wmask4),
        .R0_addr(raddr), .R0_en(re), .R0_data(d2), .R0_valid(v2)
    );

    assign r_data[0] = d0;
    assign r_data[1] = d1;
    assign r_data[2] = d2;
    assign r_valid[0] = v0;
    assign r_valid[1] = v1;
    assign r_valid[2] = v2;
    assign busy[0] = b0;
    assign busy[1] = b1;
    assign busy[2] = b2;

    // Reference model: plain arrays plus a count of clear cycles still owed.
    logic [2047:0] mem [3][256];
    int            busy_left [3];
    logic [2047:0] exp_data [3];
    logic          exp_valid [3];

    function automatic int dep(input int k);
        return (k == 2) ? 200 : 256;
    endfunction

    function automatic bit byp(input int k);
        return k != 1;
    endfunction

    function automatic int lw(input int k);
        return (k == 2) ? 512 : 1024;
    endfunction

    function automatic logic [3:0] mask_of(input int k);
        return (k == 2) ? wmask4 : {2'b00, wmask2};
    endfunction

    function automatic logic [2047:0] merge(input logic [2047:0] old_w, input logic [2047:0] new_w,
                                            input logic [3:0] m, input int lane_w);
        logic [2047:0] r;
        r = old_w;
        for (int b = 0; b < 2048; b++) begin
            if (m[b / lane_w]) r[b] = new_w[b];
        end
        return r;
    endfunction

    task automatic fill(output logic [2047:0] v);
        for (int i = 0; i < 64; i++) v[i*32 +: 32] = $urandom;
    endtask

    task automatic cycle();
        logic [2047:0] rw;
        bit            wr;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                busy_left[k] = dep(k);
                exp_valid[k] = 1'b0;
                exp_data[k]  = '0;
            end else if (busy_left[k] > 0) begin
                mem[k][dep(k) - busy_left[k]] = '0;
                busy_left[k]--;
                exp_valid[k] = 1'b0;
            end else begin
                wr = we && (int'(waddr) < dep(k));
                if (re) begin
                    rw = (int'(raddr) < dep(k)) ? mem[k][raddr] : '0;
                    if (byp(k) && wr && waddr == raddr) rw = merge(rw, wdata, mask_of(k), lw(k));
                    exp_data[k] = rw;
                end
                exp_valid[k] = re;
                if (wr) mem[k][waddr] = merge(mem[k][waddr], wdata, mask_of(k), lw(k));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wmask2 = '0; wmask4 = '0;
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy[k] !== 1'b1) begin
                bad++; $display("FAIL reset_busy[%0d] got=%b want=1", k, busy[k]);
            end
            total++;
            if (r_valid[k] !== 1'b0) begin
                bad++; $display("FAIL reset_valid[%0d] got=%b want=0", k, r_valid[k]);
            end
            total++;
            if (r_data[k] !== '0) begin
                bad++; $display("FAIL reset_data[%0d] got_lo=%h want=0", k, r_data[k][63:0]);
            end
        end
    endtask

    task automatic test_clear();
        int n0 = 0;
        int n2 = 0;
        int addrs [3] = '{0, 100, 255};
        reset = 1'b0; re = 1'b1;
        for (int c = 0; c < 260; c++) begin
            if (busy[0]) n0++;
            if (busy[2]) n2++;
            raddr = 8'($urandom_range(0, 255));
            cycle();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (busy[k] !== (busy_left[k] > 0) || r_valid[k] !== exp_valid[k] || r_data[k] !== exp_data[k]) begin
                    bad++;
                    $display("FAIL clear_seq[%0d] cyc=%0d got busy=%b valid=%b lo=%h want busy=%b valid=%b lo=%h",
                             k, c, busy[k], r_valid[k], r_data[k][63:0], busy_left[k] > 0, exp_valid[k], exp_data[k][63:0]);
                end
            end
        end
        total++;
        if (n0 !== 256) begin
            bad++; $display("FAIL clear_len_256 got=%0d want=256", n0);
        end
        total++;
        if (n2 !== 200) begin
            bad++; $display("FAIL clear_len_200 got=%0d want=200", n2);
        end
        for (int i = 0; i < 3; i++) begin
            raddr = 8'(addrs[i]);
            cycle();
            total++;
            if (r_valid[0] !== 1'b1 || r_data[0] !== '0) begin
                bad++; $display("FAIL clear_read addr=%0d got valid=%b lo=%h want valid=1 data=0", addrs[i], r_valid[0], r_data[0][63:0]);
            end
        end
    endtask

    task automatic test_masked();
        logic [2047:0] want;
        want = {{128{8'hA5}}, {1024{1'b1}}};
        re = 1'b0; we = 1'b1; waddr = 8'd5;
        wmask2 = 2'b01; wmask4 = 4'b0011; wdata = '1;
        cycle();
        wmask2 = 2'b10; wmask4 = 4'b1100; wdata = {256{8'hA5}};
        cycle();
        we = 1'b0; re = 1'b1; raddr = 8'd5;
        cycle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (r_valid[k] !== 1'b1 || r_data[k] !== want) begin
                bad++;
                $display("FAIL masked[%0d] got valid=%b hi=%h lo=%h want hi=%h lo=%h",
                         k, r_valid[k], r_data[k][2047:1984], r_data[k][63:0], want[2047:1984], want[63:0]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [2047:0] nw;
        nw = {{1024{1'b1}}, {1024{1'b0}}};
        re = 1'b0; we = 1'b1; waddr = 8'd7; wmask2 = 2'b11; wmask4 = 4'b1111; wdata = '0;
        cycle();
        wmask2 = 2'b10; wmask4 = 4'b1100; wdata = '1; re = 1'b1; raddr = 8'd7;
        cycle();
        total++;
        if (r_data[0] !== nw) begin
            bad++; $display("FAIL bypass_on got hi=%h lo=%h want hi=%h lo=0", r_data[0][2047:1984], r_data[0][63:0], nw[2047:1984]);
        end
        total++;
        if (r_data[1] !== '0) begin
            bad++; $display("FAIL bypass_off got hi=%h lo=%h want 0", r_data[1][2047:1984], r_data[1][63:0]);
        end
        total++;
        if (r_data[2] !== nw) begin
            bad++; $display("FAIL bypass_4lane got hi=%h lo=%h want hi=%h", r_data[2][2047:1984], r_data[2][63:0], nw[2047:1984]);
        end
        we = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (r_data[k] !== nw || r_valid[k] !== 1'b1) begin
                bad++; $display("FAIL bypass_after[%0d] got valid=%b hi=%h lo=%h want hi=%h lo=0", k, r_valid[k], r_data[k][2047:1984], r_data[k][63:0], nw[2047:1984]);
            end
        end
    endtask

    task automatic test_hold();
        logic [2047:0] x, y;
        fill(x);
        fill(y);
        re = 1'b0; we = 1'b1; waddr = 8'd3; wmask2 = 2'b11; wmask4 = 4'b1111; wdata = x;
        cycle();
        we = 1'b0; re = 1'b1; raddr = 8'd3;
        cycle();
        total++;
        if (r_valid[0] !== 1'b1 || r_data[0] !== x) begin
            bad++; $display("FAIL hold_first got valid=%b lo=%h want valid=1 lo=%h", r_valid[0], r_data[0][63:0], x[63:0]);
        end
        re = 1'b0; we = 1'b1; wdata = y;
        for (int c = 0; c < 2; c++) begin
            cycle();
            we = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (r_valid[k] !== 1'b0 || r_data[k] !== x) begin
                    bad++; $display("FAIL hold_idle[%0d] cyc=%0d got valid=%b lo=%h want valid=0 lo=%h", k, c, r_valid[k], r_data[k][63:0], x[63:0]);
                end
            end
        end
        re = 1'b1;
        cycle();
        total++;
        if (r_data[0] !== y) begin
            bad++; $display("FAIL hold_reread got lo=%h want lo=%h", r_data[0][63:0], y[63:0]);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int addrs [5] = '{3, 5, 7, 100, 255};
        we = 1'b0; re = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (100) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        while (busy[0] && n < 400) begin
            n++;
            cycle();
        end
        total++;
        if (n !== 256) begin
            bad++; $display("FAIL mid_reset_len got=%0d want=256", n);
        end
        re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            raddr = 8'(addrs[i]);
            cycle();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (r_valid[k] !== 1'b1 || r_data[k] !== '0) begin
                    bad++; $display("FAIL mid_reset_zero[%0d] addr=%0d got valid=%b lo=%h want valid=1 data=0", k, addrs[i], r_valid[k], r_data[k][63:0]);
                end
            end
        end
    endtask

    task automatic test_geometry();
        logic [2047:0] z, junk;
        fill(z);
        fill(junk);
        re = 1'b0; we = 1'b1; waddr = 8'd199; wmask2 = 2'b11; wmask4 = 4'b1111; wdata = z;
        cycle();
        waddr = 8'd250; wdata = junk; re = 1'b1; raddr = 8'd250;
        cycle();
        total++;
        if (r_valid[2] !== 1'b1 || r_data[2] !== '0) begin
            bad++; $display("FAIL oor_read got valid=%b lo=%h want valid=1 data=0", r_valid[2], r_data[2][63:0]);
        end
        total++;
        if (r_data[0] !== exp_data[0]) begin
            bad++; $display("FAIL addr250_full got lo=%h want lo=%h", r_data[0][63:0], exp_data[0][63:0]);
        end
        we = 1'b0; raddr = 8'd199;
        cycle();
        total++;
        if (r_data[2] !== z) begin
            bad++; $display("FAIL addr199_kept got lo=%h want lo=%h", r_data[2][63:0], z[63:0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            waddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 7));
            raddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) raddr = waddr;
            wmask2 = 2'($urandom);
            wmask4 = 4'($urandom);
            fill(wdata);
            cycle();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (busy[k] !== 1'b0 || r_valid[k] !== exp_valid[k] || r_data[k] !== exp_data[k]) begin
                    bad++;
                    $display("FAIL random[%0d] cyc=%0d got busy=%b valid=%b hi=%h lo=%h want valid=%b hi=%h lo=%h",
                             k, c, busy[k], r_valid[k], r_data[k][2047:1984], r_data[k][63:0],
                             exp_valid[k], exp_data[k][2047:1984], exp_data[k][63:0]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = 0;
            exp_valid[k] = 1'b0;
            exp_data[k]  = '0;
        end
        test_reset();
        test_clear();
        test_masked();
        test_bypass();
        test_hold();
        test_mid_reset();
        test_geometry();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

endmodule
